rfphoenix_thread_sched: RTL and testbench

Per-cycle hardware-thread scheduler for the rfPhoenix barrel pipeline, feeding a thread ID to instruction fetch. It round-robins over enabled, non-stalled threads and enforces a minimum re-issue gap per thread so that no thread re-enters fetch before its previous icache read has returned. It generalises the fixed-thread-count design: thread count, gap and counter widths are parameters, and an optional two-level priority mode is available.

---
 rtl/rfPhoenix_pkg.sv | 11 +
 rtl/rfPhoenix_rr_pick.sv | 27 ++
 rtl/rfphoenix_thread_sched.sv | 115 +++++++++++
 tb/tb_rfphoenix_thread_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rfPhoenix_pkg.sv
// Shared rfPhoenix scheduler definitions: default thread count, icache latency
// (the default minimum re-issue gap) and the thread-ID type.
package rfPhoenix_pkg;

    localparam int unsigned DEF_NTHREADS = 4;
    localparam int unsigned ICACHE_LAT   = 5;
    localparam int unsigned DEF_TIDW     = (DEF_NTHREADS > 1) ? $clog2(DEF_NTHREADS) : 1;

    typedef logic [DEF_TIDW-1:0] tid_t;

endpackage

// File: rtl/rfPhoenix_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after i_start,
// wrapping modulo N.
module rfPhoenix_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int unsigned j;
        o_found = 1'b0;
        o_idx   = '0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(i_start) + k) % N;
            if (!o_found && i_req[j]) begin
                o_found = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rfphoenix_thread_sched.sv
// Per-cycle barrel-pipeline thread scheduler with per-thread re-issue cooldown.
// Define RFPHOENIX_TSCHED_PRIO_EN to enable the two-level priority mode on prio_i.
module rfphoenix_thread_sched
    import rfPhoenix_pkg::*;
#(
    parameter int unsigned NTHREADS = DEF_NTHREADS,
    parameter int unsigned MIN_GAP  = ICACHE_LAT,
    parameter int unsigned TIDW     = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
    parameter int unsigned CNTW     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NTHREADS-1:0] thread_en_i,
    input  logic [NTHREADS-1:0] thread_stall_i,
    input  logic [NTHREADS-1:0] prio_i,
    input  logic                rdy_i,
    output logic [TIDW-1:0]     tid_o,
    output logic                vld_o,
    output logic [CNTW-1:0]     idle_cnt_o
);

    localparam int unsigned     CDW      = $clog2(MIN_GAP + 1);
    localparam logic [CDW-1:0]  CD_LOAD  = CDW'(MIN_GAP - 1);
    localparam logic [TIDW-1:0] LAST_TID = TIDW'(NTHREADS - 1);

    logic [TIDW-1:0]     r_tid;
    logic                r_vld;
    logic [TIDW-1:0]     r_last;
    logic [CNTW-1:0]     r_idle;
    logic                r_arm;
    logic [CDW-1:0]      r_cd [NTHREADS];

    logic [NTHREADS-1:0] w_elig;
    logic [TIDW-1:0]     w_start;
    logic                w_load;
    logic                w_found;
    logic [TIDW-1:0]     w_pick;
    logic                w_issue;

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < NTHREADS; i++) begin
            w_elig[i] = thread_en_i[i] & ~thread_stall_i[i] & (r_cd[i] == '0)
                      & ~(r_vld & (r_tid == TIDW'(i)));
        end
    end

    assign w_start = (r_last == LAST_TID) ? '0 : r_last + 1'b1;
    assign w_load  = ~r_vld | rdy_i;

`ifdef RFPHOENIX_TSCHED_PRIO_EN
    logic            w_hi_found, w_lo_found;
    logic [TIDW-1:0] w_hi_idx, w_lo_idx;

    rfPhoenix_rr_pick #(.N(NTHREADS), .IW(TIDW)) u_pick_hi (
        .i_req   (w_elig & prio_i),
        .i_start (w_start),
        .o_found (w_hi_found),
        .o_idx   (w_hi_idx)
    );

    rfPhoenix_rr_pick #(.N(NTHREADS), .IW(TIDW)) u_pick_lo (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_found (w_lo_found),
        .o_idx   (w_lo_idx)
    );

    assign w_found = w_hi_found | w_lo_found;
    assign w_pick  = w_hi_found ? w_hi_idx : w_lo_idx;
`else
    logic w_unused_prio;
    assign w_unused_prio = ^prio_i;

    rfPhoenix_rr_pick #(.N(NTHREADS), .IW(TIDW)) u_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );
`endif

    // r_arm holds off issue for the first edge after reset release.
    assign w_issue = w_load & w_found & r_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tid  <= '0;
            r_vld  <= 1'b0;
            r_last <= LAST_TID;
            r_idle <= '0;
            r_arm  <= 1'b0;
            for (int unsigned i = 0; i < NTHREADS; i++) r_cd[i] <= '0;
        end else begin
            r_arm <= 1'b1;
            if (w_load) begin
                r_vld <= w_issue;
                if (w_issue) begin
                    r_tid  <= w_pick;
                    r_last <= w_pick;
                end
            end
            if (!r_vld && (r_idle != '1)) r_idle <= r_idle + 1'b1;
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                if (w_issue && (w_pick == TIDW'(i))) r_cd[i] <= CD_LOAD;
                else if (r_cd[i] != '0)              r_cd[i] <= r_cd[i] - 1'b1;
            end
        end
    end

    assign tid_o      = r_tid;
    assign vld_o      = r_vld;
    assign idle_cnt_o = r_idle;

endmodule

// File: tb/tb_rfphoenix_thread_sched.sv
// Directed scoreboard bench for rfphoenix_thread_sched (gaps 5, 4 and 1).
module tb_rfphoenix_thread_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en, en1, stall, prio0, prio1;
    logic        rdy;

    logic [1:0]  tid5, tid4, tid1;
    logic        vld5, vld4, vld1;
    logic [31:0] idle5, idle4;
    logic [1:0]  idle1;

    int total = 0;
    int bad   = 0;

    logic [2:0] q5[$], q4[$], q1[$];

    always #5 clk = ~clk;

    rfphoenix_thread_sched u_dut5 (
        .clk(clk), .rst_n(rst_n), .thread_en_i(en), .thread_stall_i(stall),
        .prio_i(prio0), .rdy_i(rdy), .tid_o(tid5), .vld_o(vld5), .idle_cnt_o(idle5)
    );

    rfphoenix_thread_sched #(.MIN_GAP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .thread_en_i(en), .thread_stall_i(stall),
        .prio_i(prio0), .rdy_i(rdy), .tid_o(tid4), .vld_o(vld4), .idle_cnt_o(idle4)
    );

    rfphoenix_thread_sched #(.MIN_GAP(1), .CNTW(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .thread_en_i(en1), .thread_stall_i(4'b0000),
        .prio_i(prio1), .rdy_i(1'b1), .tid_o(tid1), .vld_o(vld1), .idle_cnt_o(idle1)
    );

    // {vld, tid}; 3'b0xx is a bubble with the held tid.
    localparam logic [2:0] P1_5 [10] = '{3'h4, 3'h5, 3'h6, 3'h7, 3'h3, 3'h4, 3'h5, 3'h6, 3'h7, 3'h3};
    localparam logic [2:0] P1_4 [10] = '{3'h4, 3'h5, 3'h6, 3'h7, 3'h4, 3'h5, 3'h6, 3'h7, 3'h4, 3'h5};
`ifdef RFPHOENIX_TSCHED_PRIO_EN
    localparam logic [2:0] P1_1 [10] = '{3'h7, 3'h4, 3'h7, 3'h4, 3'h7, 3'h4, 3'h7, 3'h4, 3'h7, 3'h4};
`else
    localparam logic [2:0] P1_1 [10] = '{3'h4, 3'h5, 3'h6, 3'h7, 3'h4, 3'h5, 3'h6, 3'h7, 3'h4, 3'h5};
`endif
    localparam logic [2:0] P2_5 [10] = '{3'h4, 3'h0, 3'h6, 3'h7, 3'h3, 3'h4, 3'h0, 3'h6, 3'h7, 3'h3};
    localparam logic [2:0] P3_5 [5]  = '{3'h4, 3'h5, 3'h6, 3'h7, 3'h3};
    localparam logic [2:0] P4_5 [10] = '{3'h4, 3'h5, 3'h6, 3'h6, 3'h6, 3'h6, 3'h7, 3'h4, 3'h5, 3'h6};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [2:0] e;
        @(posedge clk);
        #1;
        if (q5.size() > 0) begin e = q5.pop_front(); chk("seq5", {29'd0, vld5, tid5}, {29'd0, e}); end
        if (q4.size() > 0) begin e = q4.pop_front(); chk("seq4", {29'd0, vld4, tid4}, {29'd0, e}); end
        if (q1.size() > 0) begin e = q1.pop_front(); chk("seq1", {29'd0, vld1, tid1}, {29'd0, e}); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 4'h0;
        en1   = 4'h0;
        stall = 4'h0;
        prio0 = 4'h0;
        prio1 = 4'b1000;
        rdy   = 1'b1;
        step();
        step();
        chk("rst_vld", {31'd0, vld5}, 32'd0);
        chk("rst_tid", {30'd0, tid5}, 32'd0);
        chk("rst_idle", idle5, 32'd0);

        // first edge after release never issues
        en    = 4'hF;
        en1   = 4'hF;
        rst_n = 1'b1;
        q5.push_back(3'h0); q4.push_back(3'h0); q1.push_back(3'h0);
        step();

        for (int k = 0; k < 10; k++) begin
            q5.push_back(P1_5[k]); q4.push_back(P1_4[k]); q1.push_back(P1_1[k]);
            step();
        end
        chk("idle5_p1", idle5, 32'd3);
        chk("idle4_p1", idle4, 32'd2);
        chk("idle1_p1", {30'd0, idle1}, 32'd2);

        stall = 4'b0010;
        en1   = 4'h0;
        for (int k = 0; k < 10; k++) begin
            q5.push_back(P2_5[k]);
            step();
            if (k == 2) begin
                chk("idle1_sat", {30'd0, idle1}, 32'd3);
                chk("vld1_off", {31'd0, vld1}, 32'd0);
            end
        end

        stall = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            q5.push_back(P3_5[k]);
            step();
        end

        for (int k = 0; k < 10; k++) begin
            rdy   = !(k >= 3 && k <= 5);
            stall = (k == 4 || k == 5) ? 4'b0100 : 4'b0000;
            q5.push_back(P4_5[k]);
            step();
        end
        rdy   = 1'b1;
        stall = 4'b0000;

        rst_n = 1'b0;
        #1;
        chk("async_vld", {31'd0, vld5}, 32'd0);
        chk("async_idle", idle5, 32'd0);
        chk("async_tid", {30'd0, tid5}, 32'd0);
        step();
        rst_n = 1'b1;
        q5.push_back(3'h0);
        step();
        q5.push_back(3'h4);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
